// File: rtl/mmio_master_pkg.sv
// Shared encodings for the MEM-stage bus initiator: access sizes, FSM states,
// the HWInt vector width and the device window decode helper.
package mmio_master_pkg;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

   localparam int HWINT_W = 6;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CHECK = 3'd1,
      ST_READ  = 3'd2,
      ST_WRITE = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   // A device window covers three consecutive words starting at base.
   function automatic logic in_window(input logic [31:0] waddr, input logic [31:0] base);
      return (waddr >= base) && (waddr <= (base + 32'd8));
   endfunction

endpackage

// File: rtl/mmio_master_lane_unit.sv
// Byte-lane steering: merges sub-word store data into a read word and
// extracts/extends a sub-word lane for loads. Lanes are little-endian.
module lane_unit
   import mmio_master_pkg::*;
(
   input  logic [31:0] rword_i,
   input  logic [31:0] wdata_i,
   input  logic [1:0]  off_i,
   input  logic [1:0]  size_i,
   input  logic        sext_i,
   output logic [31:0] merged_o,
   output logic [31:0] rdata_o
);

   logic [7:0]  byte_d;
   logic [15:0] half_d;

   // Store merge: replace only the addressed lane of the word read back.
   always_comb begin
      merged_o = rword_i;
      case (size_i)
         SZ_BYTE: begin
            case (off_i)
               2'd0:    merged_o[7:0]   = wdata_i[7:0];
               2'd1:    merged_o[15:8]  = wdata_i[7:0];
               2'd2:    merged_o[23:16] = wdata_i[7:0];
               2'd3:    merged_o[31:24] = wdata_i[7:0];
               default: merged_o        = rword_i;
            endcase
         end
         SZ_HALF: begin
            if (off_i[1]) begin
               merged_o[31:16] = wdata_i[15:0];
            end else begin
               merged_o[15:0]  = wdata_i[15:0];
            end
         end
         default: merged_o = wdata_i;
      endcase
   end

   // Load extract: pick the lane, then sign- or zero-extend it.
   always_comb begin
      byte_d = 8'h00;
      half_d = 16'h0000;
      case (off_i)
         2'd0:    byte_d = rword_i[7:0];
         2'd1:    byte_d = rword_i[15:8];
         2'd2:    byte_d = rword_i[23:16];
         2'd3:    byte_d = rword_i[31:24];
         default: byte_d = 8'h00;
      endcase
      if (off_i[1]) begin
         half_d = rword_i[31:16];
      end else begin
         half_d = rword_i[15:0];
      end
      case (size_i)
         SZ_BYTE: rdata_o = {{24{sext_i & byte_d[7]}}, byte_d};
         SZ_HALF: rdata_o = {{16{sext_i & half_d[15]}}, half_d};
         default: rdata_o = rword_i;
      endcase
   end

endmodule

// File: rtl/mmio_master.sv
// MEM-stage to bridge initiator: one load/store per request, read-modify-write
// for sub-word stores, registered bus outputs and registered HWInt vector.
module mmio_master
   import mmio_master_pkg::*;
#(
   parameter logic [31:0] DEV0_BASE = 32'h00007f00,
   parameter logic [31:0] DEV1_BASE = 32'h00007f10
)(
   input  logic               clk,
   input  logic               reset,
   input  logic               req,
   input  logic               req_we,
   input  logic [1:0]         req_size,
   input  logic               req_sext,
   input  logic [31:0]        req_addr,
   input  logic [31:0]        req_wdata,
   output logic               busy,
   output logic               done,
   output logic               err,
   output logic [31:0]        rdata,
   output logic [31:0]        Addr,
   output logic               WE,
   output logic [31:0]        Din,
   input  logic [31:0]        Dout,
   input  logic               IRQ0,
   input  logic               IRQ1,
   output logic [HWINT_W-1:0] hwint
);

   state_t              state_q;
   logic                we_q;
   logic                sext_q;
   logic [1:0]          size_q;
   logic [31:0]         addr_q;
   logic [31:0]         wdata_q;
   logic                busy_q;
   logic                done_q;
   logic                err_q;
   logic [31:0]         rdata_q;
   logic [31:0]         bus_addr_q;
   logic                bus_we_q;
   logic [31:0]         bus_din_q;
   logic [HWINT_W-1:0]  hwint_q;

   logic [31:0]         waddr_d;
   logic                size_err_d;
   logic                err_d;
   logic [31:0]         merged_d;
   logic [31:0]         ext_d;

   assign waddr_d = {addr_q[31:2], 2'b00};

   // Decode of the latched request: alignment, legal size and window hit.
   always_comb begin
      size_err_d = 1'b0;
      case (size_q)
         SZ_BYTE: size_err_d = 1'b0;
         SZ_HALF: size_err_d = addr_q[0];
         SZ_WORD: size_err_d = (addr_q[1:0] != 2'b00);
         default: size_err_d = 1'b1;
      endcase
      err_d = size_err_d
            | ~(in_window(waddr_d, DEV0_BASE) | in_window(waddr_d, DEV1_BASE));
   end

   // Dout is only consulted in READ, so the lane unit works on it directly;
   // this lets merge/extract results land in the registers at the READ edge.
   lane_unit u_lane (
      .rword_i  (Dout),
      .wdata_i  (wdata_q),
      .off_i    (addr_q[1:0]),
      .size_i   (size_q),
      .sext_i   (sext_q),
      .merged_o (merged_d),
      .rdata_o  (ext_d)
   );

   // Request FSM with all bus and status outputs registered.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         we_q       <= 1'b0;
         sext_q     <= 1'b0;
         size_q     <= 2'b00;
         addr_q     <= 32'h0000_0000;
         wdata_q    <= 32'h0000_0000;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         rdata_q    <= 32'h0000_0000;
         bus_addr_q <= 32'h0000_0000;
         bus_we_q   <= 1'b0;
         bus_din_q  <= 32'h0000_0000;
      end else begin
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         bus_addr_q <= 32'h0000_0000;
         bus_we_q   <= 1'b0;
         bus_din_q  <= 32'h0000_0000;
         case (state_q)
            ST_IDLE: begin
               if (req && !busy_q) begin
                  we_q    <= req_we;
                  sext_q  <= req_sext;
                  size_q  <= req_size;
                  addr_q  <= req_addr;
                  wdata_q <= req_wdata;
                  busy_q  <= 1'b1;
                  state_q <= ST_CHECK;
               end else begin
                  state_q <= ST_IDLE;
               end
            end
            ST_CHECK: begin
               if (err_d) begin
                  done_q  <= 1'b1;
                  err_q   <= 1'b1;
                  rdata_q <= 32'h0000_0000;
                  state_q <= ST_DONE;
               end else if (we_q && (size_q == SZ_WORD)) begin
                  bus_addr_q <= waddr_d;
                  bus_we_q   <= 1'b1;
                  bus_din_q  <= wdata_q;
                  state_q    <= ST_WRITE;
               end else begin
                  bus_addr_q <= waddr_d;
                  state_q    <= ST_READ;
               end
            end
            ST_READ: begin
               if (we_q) begin
                  bus_addr_q <= waddr_d;
                  bus_we_q   <= 1'b1;
                  bus_din_q  <= merged_d;
                  state_q    <= ST_WRITE;
               end else begin
                  done_q  <= 1'b1;
                  rdata_q <= ext_d;
                  state_q <= ST_DONE;
               end
            end
            ST_WRITE: begin
               done_q  <= 1'b1;
               rdata_q <= 32'h0000_0000;
               state_q <= ST_DONE;
            end
            ST_DONE: begin
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   // Interrupt lines are sampled every cycle regardless of bus activity.
   always_ff @(posedge clk) begin
      if (reset) begin
         hwint_q <= {HWINT_W{1'b0}};
      end else begin
         hwint_q <= {4'b0000, IRQ1, IRQ0};
      end
   end

   assign busy  = busy_q;
   assign done  = done_q;
   assign err   = err_q;
   assign rdata = rdata_q;
   assign Addr  = bus_addr_q;
   assign WE    = bus_we_q;
   assign Din   = bus_din_q;
   assign hwint = hwint_q;

endmodule
